// File: rtl/hazard_scheduler.sv
// hazard_scheduler: tracks in-flight destination registers/opcodes for the
// decode-stage hazard lookahead, and sequences fetch around control-flow
// instructions (hold while a branch/jump resolves, flush IF/ID on taken).
module hazard_scheduler #(
  parameter int unsigned BR_TIMEOUT   = 8,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_writes,
  input  logic [4:0]  issue_rd,
  input  logic [5:0]  issue_op,
  input  logic [5:0]  issue_func,
  input  logic        decode_stall,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic [4:0]  rd_fut_1,
  output logic [4:0]  rd_fut_2,
  output logic [4:0]  rd_fut_3,
  output logic [5:0]  op_fut_1,
  output logic [5:0]  op_fut_2,
  output logic        pc_hold,
  output logic        flush_ifid,
  output logic        br_pending,
  output logic        timeout_err,
  output logic        proto_err,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Wait counter starts at 0 on entry, so leaving at BR_TIMEOUT-1 gives
  // exactly BR_TIMEOUT cycles in BR_WAIT.
  localparam logic [7:0] WAIT_LAST  = 8'(BR_TIMEOUT - 1);
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  flush_q, flush_d;
  logic [4:0]  rd1_q, rd1_d, rd2_q, rd3_q;
  logic [5:0]  op1_q, op1_d, op2_q;
  logic        terr_q, terr_d;
  logic        perr_q, perr_d;
  logic [15:0] scnt_q, scnt_d;
  logic        is_ctrl;

  // Control-flow decode: beq, bne, j, jal, or R-type jr.
  always_comb begin
    is_ctrl = (issue_op == 6'b000100) || (issue_op == 6'b000101) ||
              (issue_op == 6'b000010) || (issue_op == 6'b000011) ||
              ((issue_op == 6'b000000) && (issue_func == 6'b001000));
  end

  // Newest slot capture; register 0 and non-writing instructions read as empty.
  always_comb begin
    rd1_d = (issue_valid && issue_writes && (issue_rd != 5'd0)) ? issue_rd : '0;
    op1_d = issue_valid ? issue_op : '0;
  end

  // FSM next-state, counters and sticky error flags.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    flush_d = flush_q;
    terr_d  = terr_q;
    perr_d  = perr_q | (issue_valid & (state_q != RUN));
    case (state_q)
      RUN: begin
        if (issue_valid && is_ctrl) begin
          state_d = BR_WAIT;
          wait_d  = '0;
        end
      end
      BR_WAIT: begin
        // A resolve wins over a timeout landing in the same cycle.
        if (resolve_valid) begin
          if (resolve_taken) begin
            state_d = FLUSH;
            flush_d = FLUSH_INIT;
          end else begin
            state_d = RUN;
          end
        end else if (wait_q >= WAIT_LAST) begin
          state_d = RUN;
          terr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      FLUSH: begin
        if (flush_q <= 2'd1) begin
          state_d = RUN;
          flush_d = '0;
        end else begin
          flush_d = flush_q - 2'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Fetch-control outputs decoded from the current state.
  always_comb begin
    br_pending = (state_q == BR_WAIT);
    flush_ifid = (state_q == FLUSH);
    pc_hold    = decode_stall | br_pending | flush_ifid;
    scnt_d     = (pc_hold && (scnt_q != '1)) ? scnt_q + 16'd1 : scnt_q;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      flush_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rd3_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      terr_q  <= 1'b0;
      perr_q  <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      flush_q <= flush_d;
      rd3_q   <= rd2_q;
      rd2_q   <= rd1_q;
      rd1_q   <= rd1_d;
      op2_q   <= op1_q;
      op1_q   <= op1_d;
      terr_q  <= terr_d;
      perr_q  <= perr_d;
      scnt_q  <= scnt_d;
    end
  end

  assign rd_fut_1    = rd1_q;
  assign rd_fut_2    = rd2_q;
  assign rd_fut_3    = rd3_q;
  assign op_fut_1    = op1_q;
  assign op_fut_2    = op2_q;
  assign timeout_err = terr_q;
  assign proto_err   = perr_q;
  assign stall_count = scnt_q;

endmodule
